// File: rtl/t_table_server_if.sv
// Term-stream and T read-port bundle for t_table_server.
// The master side is the term generator / Emin stage; the slave side is the table server.
interface t_table_server_if #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160
);
    localparam int AW = $clog2(I);

    // Handshake: a term triple transfers on a rising clk_in edge where
    // term_valid_in && term_ready_out; valid without ready is dropped, not held.
    logic                        start_in;
    logic                        term_valid_in;
    logic signed [BIT_WIDTH-1:0] term0_in;
    logic signed [BIT_WIDTH-1:0] term1_in;
    logic signed [BIT_WIDTH-1:0] term2_in;
    logic                        term_ready_out;
    logic                        build_done_out;
    logic [AW-1:0]               T_req;
    logic [BIT_WIDTH-1:0]        T_resp0;
    logic [BIT_WIDTH-1:0]        T_resp1;
    logic [BIT_WIDTH-1:0]        T_resp2;

    modport master (
        output start_in, term_valid_in, term0_in, term1_in, term2_in, T_req,
        input  term_ready_out, build_done_out, T_resp0, T_resp1, T_resp2
    );

    modport slave (
        input  start_in, term_valid_in, term0_in, term1_in, term2_in, T_req,
        output term_ready_out, build_done_out, T_resp0, T_resp1, T_resp2
    );
endinterface

// File: rtl/t_table_server.sv
// Builds the cumulative table T(nu, x) from a term stream and serves it with 2-cycle read latency.
// Optional macro T_TABLE_SAT_EN makes each accumulator add saturate instead of wrap.
module t_table_server #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int NU_VALUES = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    t_table_server_if.slave   bus,
    output logic [1:0]        state_dbg_out
);
    localparam int AW = $clog2(I);
    localparam int XW = $clog2(I + 1);
    localparam int RW = NU_VALUES * BIT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_SERVE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [XW-1:0]               wr_x_q, wr_x_d;
    logic signed [BIT_WIDTH-1:0] acc_q [NU_VALUES];
    logic signed [BIT_WIDTH-1:0] acc_d [NU_VALUES];
    logic                        done_q, done_d;
    logic [AW-1:0]               rd_addr_q, rd_addr_d;
    logic                        rd_hit_q, rd_hit_d;
    logic [RW-1:0]               row_q, row_d;
    logic [RW-1:0]               resp_q, resp_d;

    // Table storage has no reset; reads of unwritten rows are masked by the hit flag.
    logic [RW-1:0]               mem_q [I];
    logic                        mem_we;
    logic [AW-1:0]               mem_waddr;
    logic [RW-1:0]               mem_wdata;

    logic signed [BIT_WIDTH-1:0] term_v [NU_VALUES];
    logic signed [BIT_WIDTH-1:0] sum_v  [NU_VALUES];
    logic                        term_ready;
    logic                        accept;

    function automatic logic signed [BIT_WIDTH-1:0] acc_add(
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b
    );
        logic signed [BIT_WIDTH-1:0] s;
        s = a + b;
`ifdef T_TABLE_SAT_EN
        // Overflow only when both operands share a sign that the result lost.
        if ((a[BIT_WIDTH-1] == b[BIT_WIDTH-1]) && (s[BIT_WIDTH-1] != a[BIT_WIDTH-1])) begin
            s = a[BIT_WIDTH-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                               : {1'b0, {(BIT_WIDTH-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    always_comb begin
        term_v[0] = bus.term0_in;
        term_v[1] = bus.term1_in;
        term_v[2] = bus.term2_in;
        for (int nu = 0; nu < NU_VALUES; nu++) begin
            sum_v[nu] = acc_add(acc_q[nu], term_v[nu]);
        end
    end

    // Build FSM: next state, accumulators and table write.
    always_comb begin
        state_d   = state_q;
        wr_x_d    = wr_x_q;
        acc_d     = acc_q;
        done_d    = done_q;
        mem_we    = 1'b0;
        mem_waddr = wr_x_q[AW-1:0];
        mem_wdata = '0;
        term_ready = (state_q == S_BUILD);
        accept     = term_ready && bus.term_valid_in;

        // start wins over a term accepted in the same cycle.
        if (bus.start_in) begin
            state_d = S_BUILD;
            wr_x_d  = '0;
            done_d  = 1'b0;
            for (int nu = 0; nu < NU_VALUES; nu++) acc_d[nu] = '0;
        end else if (accept) begin
            mem_we = 1'b1;
            for (int nu = 0; nu < NU_VALUES; nu++) begin
                acc_d[nu] = sum_v[nu];
                mem_wdata[nu*BIT_WIDTH +: BIT_WIDTH] = sum_v[nu];
            end
            wr_x_d = wr_x_q + 1'b1;
            if (wr_x_q == XW'(I - 1)) begin
                state_d = S_SERVE;
                done_d  = 1'b1;
            end
        end
    end

    // Read pipeline: hit uses wr_x before the edge, so a row written on edge k
    // is first readable by an address sampled on edge k+1.
    always_comb begin
        rd_addr_d = bus.T_req;
        rd_hit_d  = (XW'(bus.T_req) < wr_x_q) && (32'(bus.T_req) < 32'(I));
        row_d     = rd_hit_q ? mem_q[rd_addr_q] : '0;
        resp_d    = row_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            wr_x_q    <= '0;
            acc_q     <= '{default: '0};
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_hit_q  <= 1'b0;
            row_q     <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_x_q    <= wr_x_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            rd_addr_q <= rd_addr_d;
            rd_hit_q  <= rd_hit_d;
            row_q     <= row_d;
            resp_q    <= resp_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.term_ready_out = term_ready;
    assign bus.build_done_out = done_q;
    assign bus.T_resp0        = resp_q[0*BIT_WIDTH +: BIT_WIDTH];
    assign bus.T_resp1        = resp_q[1*BIT_WIDTH +: BIT_WIDTH];
    assign bus.T_resp2        = resp_q[2*BIT_WIDTH +: BIT_WIDTH];
    assign state_dbg_out      = state_q;
endmodule

// File: tb/tb_t_table_server.sv
// Self-checking bench for t_table_server: randomized term/read stimulus against a
// table-level reference model, plus literal checks of the documented scenarios.
module tb_t_table_server;
    localparam int BW = 32;
    localparam int I  = 160;
    localparam int AW = $clog2(I);

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] state_dbg;

    t_table_server_if #(.BIT_WIDTH(BW), .I(I)) bus ();

    t_table_server #(.BIT_WIDTH(BW), .I(I), .NU_VALUES(3)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bus           (bus),
        .state_dbg_out (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    int ready_cnt = 0;

    // Reference model: building flag, count of rows built, running sums, table, read queue.
    bit          m_building = 1'b0;
    int          m_rows = 0;
    bit          m_done = 1'b0;
    logic [BW-1:0] m_acc [3];
    logic [BW-1:0] m_tab [I][3];
    logic [BW-1:0] rd_q [$];
    logic [BW-1:0] e_resp [3];
    logic [BW-1:0] t_in [3];
    int          req_i;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] ref_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint s;
        longint maxv;
        longint minv;
        logic [63:0] sv;
        maxv = (longint'(1) <<< (BW - 1)) - 1;
        minv = -(longint'(1) <<< (BW - 1));
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef T_TABLE_SAT_EN
        if (s > maxv) s = maxv;
        if (s < minv) s = minv;
`else
        if (s > maxv || s < minv) s = s;
`endif
        sv = s;
        return sv[BW-1:0];
    endfunction

    task automatic model_reset();
        m_building = 1'b0;
        m_rows = 0;
        m_done = 1'b0;
        rd_q.delete();
        for (int k = 0; k < 6; k++) rd_q.push_back('0);
        for (int nu = 0; nu < 3; nu++) begin
            m_acc[nu] = '0;
            e_resp[nu] = '0;
        end
    endtask

    initial model_reset();

    // Model update on every active edge (or asynchronous reset).
    initial forever begin
        @(posedge clk_in or negedge rst_in);
        if (!rst_in) begin
            model_reset();
        end else begin
            for (int nu = 0; nu < 3; nu++) e_resp[nu] = rd_q.pop_front();
            req_i = int'(bus.T_req);
            for (int nu = 0; nu < 3; nu++) begin
                if (req_i < m_rows && req_i < I) rd_q.push_back(m_tab[req_i][nu]);
                else rd_q.push_back('0);
            end
            t_in[0] = bus.term0_in;
            t_in[1] = bus.term1_in;
            t_in[2] = bus.term2_in;
            if (bus.start_in) begin
                m_building = 1'b1;
                m_rows = 0;
                m_done = 1'b0;
                for (int nu = 0; nu < 3; nu++) m_acc[nu] = '0;
            end else if (m_building && bus.term_valid_in) begin
                for (int nu = 0; nu < 3; nu++) begin
                    m_acc[nu] = ref_add(m_acc[nu], t_in[nu]);
                    m_tab[m_rows][nu] = m_acc[nu];
                end
                m_rows++;
                if (m_rows == I) begin
                    m_building = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs are checked against the model every cycle.
    initial forever begin
        @(negedge clk_in);
        if (bus.term_ready_out === 1'b1) ready_cnt++;
        if (cmp_en) begin
            chk("term_ready", 32'(bus.term_ready_out), 32'(m_building));
            chk("build_done", 32'(bus.build_done_out), 32'(m_done));
            chk("T_resp0", bus.T_resp0, e_resp[0]);
            chk("T_resp1", bus.T_resp1, e_resp[1]);
            chk("T_resp2", bus.T_resp2, e_resp[2]);
        end
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic pulse_start();
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
    endtask

    // mode 0: (1,2,-1) dense; mode 1: random with gaps and restarts; mode 2: random dense.
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                bus.term_valid_in = 1'b0;
                bus.T_req = AW'($urandom_range(0, 255));
                tick();
            end
            bus.term_valid_in = 1'b1;
            bus.start_in = (mode == 1 && $urandom_range(0, 60) == 0);
            bus.T_req = AW'($urandom_range(0, 255));
            if (mode == 0) begin
                bus.term0_in = 1;
                bus.term1_in = 2;
                bus.term2_in = -1;
            end else begin
                bus.term0_in = $urandom;
                bus.term1_in = $urandom_range(0, 1) ? $urandom : BW'($urandom_range(0, 100));
                bus.term2_in = -BW'($urandom_range(0, 1000));
            end
            tick();
            bus.start_in = 1'b0;
        end
        bus.term_valid_in = 1'b0;
    endtask

    task automatic read_lit(input string name, input int addr,
                            input logic [BW-1:0] e0, input logic [BW-1:0] e1, input logic [BW-1:0] e2);
        bus.T_req = AW'(addr);
        tick();
        tick();
        tick();
        chk({name, "_r0"}, bus.T_resp0, e0);
        chk({name, "_r1"}, bus.T_resp1, e1);
        chk({name, "_r2"}, bus.T_resp2, e2);
    endtask

    task automatic check_zero_now(input string name);
        chk({name, "_ready"}, 32'(bus.term_ready_out), 0);
        chk({name, "_done"}, 32'(bus.build_done_out), 0);
        chk({name, "_r0"}, bus.T_resp0, 0);
        chk({name, "_r1"}, bus.T_resp1, 0);
        chk({name, "_r2"}, bus.T_resp2, 0);
        chk({name, "_state"}, 32'(state_dbg), 0);
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.term_valid_in = 1'b0;
        bus.term0_in = '0;
        bus.term1_in = '0;
        bus.term2_in = '0;
        bus.T_req = '0;

        #2 rst_in = 1'b0;
        cmp_en = 1'b1;
        #1 check_zero_now("reset");
        tick();
        tick();
        rst_in = 1'b1;
        tick();

        // Full build of (1,2,-1) terms.
        ready_cnt = 0;
        pulse_start();
        feed(I, 0);
        chk("done_after_last", 32'(bus.build_done_out), 1);
        chk("ready_after_last", 32'(bus.term_ready_out), 0);
        tick();
        tick();
        chk("ready_cycles", ready_cnt, I);
        read_lit("read9", 9, 10, 20, -10);

        // Back-to-back reads of 159 then 0.
        bus.T_req = AW'(159);
        tick();
        bus.T_req = AW'(0);
        tick();
        tick();
        chk("b2b159_r0", bus.T_resp0, 160);
        chk("b2b159_r1", bus.T_resp1, 320);
        chk("b2b159_r2", bus.T_resp2, -160);
        tick();
        chk("b2b0_r0", bus.T_resp0, 1);
        chk("b2b0_r1", bus.T_resp1, 2);
        chk("b2b0_r2", bus.T_resp2, -1);

        // Partial build of 5 rows.
        pulse_start();
        feed(5, 0);
        read_lit("partial7", 7, 0, 0, 0);
        read_lit("partial4", 4, 5, 10, -5);
        read_lit("oob200", 200, 0, 0, 0);

        // Column-0 overflow across the first two rows.
        pulse_start();
        bus.term_valid_in = 1'b1;
        bus.term0_in = 32'h7FFF_FFF0;
        bus.term1_in = '0;
        bus.term2_in = '0;
        tick();
        bus.term0_in = 32'h0000_0020;
        tick();
        bus.term_valid_in = 1'b0;
`ifdef T_TABLE_SAT_EN
        read_lit("sat", 1, 32'h7FFF_FFFF, 0, 0);
`else
        read_lit("wrap", 1, 32'h8000_0010, 0, 0);
`endif

        // Randomized builds with gaps, restarts and random reads.
        for (int r = 0; r < 4; r++) begin
            pulse_start();
            feed($urandom_range(60, 200), 1);
            for (int k = 0; k < 30; k++) begin
                bus.T_req = AW'($urandom_range(0, 255));
                bus.term_valid_in = $urandom_range(0, 1);
                tick();
            end
            bus.term_valid_in = 1'b0;
        end

        // Clean random build to SERVE, then restart with a simultaneous term.
        pulse_start();
        feed(I, 2);
        chk("serve_done", 32'(bus.build_done_out), 1);
        bus.start_in = 1'b1;
        bus.term_valid_in = 1'b1;
        bus.term0_in = 7;
        bus.term1_in = 7;
        bus.term2_in = 7;
        tick();
        bus.start_in = 1'b0;
        bus.term_valid_in = 1'b0;
        chk("restart_done_fall", 32'(bus.build_done_out), 0);
        read_lit("restart_read0", 0, 0, 0, 0);
        feed(1, 0);
        read_lit("restart_first", 0, 1, 2, -1);

        // Asynchronous reset in the middle of a build.
        pulse_start();
        feed(50, 0);
        #2 rst_in = 1'b0;
        #1 check_zero_now("midreset");
        tick();
        tick();
        rst_in = 1'b1;
        tick();
        read_lit("postreset0", 0, 0, 0, 0);
        read_lit("postreset49", 49, 0, 0, 0);

        tick();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/t_table_server.md
Name: t_table_server

Overview:
- Builds the cumulative table T(nu, x) for nu = 0..2 and x = 0..I-1 from a stream of per-index terms.
- Serves the table through the T_req / T_resp0..2 read interface with a fixed 2-cycle read latency.
- Sits between the front-end term generator and the Emin stage. It is the responder end of the T read port.

Parameters:
- BIT_WIDTH, 32, width of each signed term and table entry.
- I, 160, number of table indices; address width is $clog2(I).
- NU_VALUES, 3, number of nu columns; fixed at 3 because there are three response ports.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse that begins a new build.
- term_valid_in  input  1  term triple valid.
- term0_in / term1_in / term2_in  input  BIT_WIDTH each  signed terms for index x.
- term_ready_out  output  1  block accepts a term this cycle.
- build_done_out  output  1  table is complete and valid.
- T_req  input  $clog2(I)  read address.
- T_resp0 / T_resp1 / T_resp2  output  BIT_WIDTH each  T(0..2, T_req).

Behaviour:
- Reset (rst_in low, asynchronous):
  - state IDLE, write index wr_x = 0, accumulators = 0.
  - term_ready_out = 0, build_done_out = 0.
  - read pipeline registers and T_resp0..2 = 0.
  - Memory contents are undefined after reset and are masked as described below.
- States: IDLE, BUILD, SERVE.
- IDLE:
  - term_ready_out = 0.
  - start_in -> BUILD, wr_x <= 0, accumulators <= 0, build_done_out <= 0.
- BUILD:
  - term_ready_out = 1.
  - A term is accepted on term_valid_in && term_ready_out.
  - On accept: acc[nu] <= acc[nu] + term_nu; mem[wr_x][nu] <= acc[nu] + term_nu; wr_x <= wr_x + 1.
  - All three columns are written in the same cycle.
  - Accepting at wr_x == I-1 -> SERVE. term_ready_out drops in the following cycle; build_done_out <= 1 on that same edge.
  - term_valid_in while term_ready_out = 0 is ignored; no write, no error.
- SERVE:
  - Table is frozen; term inputs are ignored.
  - start_in -> BUILD, with the same clearing as from IDLE; build_done_out drops on the next edge.
- start_in in BUILD: build restarts (wr_x <= 0, accumulators cleared). start_in has priority over a term accepted in the same cycle, which is discarded.
- Reads are always active in every state:
  - edge k: the address is registered along with a flag hit = (T_req < wr_x) && (T_req < I).
  - edge k+1: the memory row is registered.
  - edge k+2: T_resp0..2 <= hit ? row : 0.
  - Net effect: T_resp reflects T_req sampled 2 edges earlier, and a new address can be issued every cycle.
- Unwritten or out-of-range addresses return 0. This covers rows not yet built in the current build and any address >= I.
- Read-during-write on the same index: the write that commits on edge k is visible to a read whose address is sampled on edge k+1 or later. The hit flag uses wr_x before the edge.
- Arithmetic: signed two's complement at BIT_WIDTH. Without the optional feature, sums wrap.
- Reset mid-build forces IDLE immediately. build_done_out = 0 until a full new build completes.

Optional Feature:
- Macro: T_TABLE_SAT_EN.
- Defined: each accumulator add saturates to +2^(BIT_WIDTH-1)-1 or -2^(BIT_WIDTH-1). Saturation is detected per column from the operand signs and the result sign. The saturated value is both stored and carried forward as the new acc.
- Undefined: plain wrapping add.

Test Plan:
- Reset, then start_in, then 160 terms (1, 2, -1) back-to-back:
  - term_ready_out = 1 for exactly 160 cycles.
  - build_done_out rises 1 cycle after the last accept.
  - T_req = 9 then reads (10, 20, -10) two cycles later.
- Read 159 then 0 on consecutive cycles after the build:
  - responses (160, 320, -160), then (1, 2, -1), on consecutive cycles.
- Partial build of 5 terms, then read address 7:
  - response (0, 0, 0).
  - read of address 4 -> (5, 10, -5).
- Term at x=0 of 0x7FFFFFF0 followed by +0x20 in column 0:
  - without T_TABLE_SAT_EN, T(0,1) = 0x80000010.
  - with it, T(0,1) = 0x7FFFFFFF.
- start_in pulsed in SERVE, plus a term in the same cycle:
  - build_done_out falls next edge.
  - the term is discarded.
  - read of address 0 returns 0 until a new term is accepted.
- rst_in asserted low mid-build (wr_x = 50) asynchronously between edges:
  - all outputs are immediately 0.
  - state IDLE.
  - reads return 0 after release.
